// File: rtl/pc_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Shared encodings for the PC fetch unit: the pc_src select values, the fetch
// FSM states and the default reset PC.
// No ports (package).
// ----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Next-PC select coming from the PC-source decode.
  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pc_src_e;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_VALID = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// ----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC computation. All arithmetic wraps modulo
// 2^ADDR_W. ADDR_W is expected to be 32 (the jump target keeps pc_plus4
// bits [ADDR_W-1:28] above the 26-bit index).
// Ports:
//   pc_i            current PC
//   pc_src_i        select: 00 PC+4, 01 branch, 10 jump, 11 reserved (PC+4)
//   branch_offset_i sign-extended branch immediate, in words
//   jump_index_i    26-bit jump index field
//   next_pc_o       selected next PC
//   pc_plus4_o      pc_i + 4
// ----------------------------------------------------------------------------
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [1:0]        pc_src_i,
  input  logic [31:0]       branch_offset_i,
  input  logic [25:0]       jump_index_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  logic [ADDR_W-1:0] branch_disp_s;
  logic [ADDR_W-1:0] branch_tgt_s;
  logic [ADDR_W-1:0] jump_tgt_s;

  assign pc_plus4_o    = pc_i + ADDR_W'(32'd4);
  // Word offset to byte displacement; the top two offset bits fall off,
  // which is exactly the modulo-2^32 result.
  assign branch_disp_s = ADDR_W'($signed({branch_offset_i[29:0], 2'b00}));
  assign branch_tgt_s  = pc_plus4_o + branch_disp_s;
  assign jump_tgt_s    = {pc_plus4_o[ADDR_W-1:28], jump_index_i, 2'b00};

  // Select the next PC; the reserved encoding behaves like PC+4.
  always_comb begin
    next_pc_o = pc_plus4_o;
    case (pc_src_i)
      PCSRC_PLUS4:  next_pc_o = pc_plus4_o;
      PCSRC_BRANCH: next_pc_o = branch_tgt_s;
      PCSRC_JUMP:   next_pc_o = jump_tgt_s;
      PCSRC_RSVD:   next_pc_o = pc_plus4_o;
      default:      next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Owns the program counter and fetches one instruction per committed PC over
// a req/ready instruction-memory handshake (IDLE -> REQ -> VALID -> REQ ...).
// Optional feature macro: PC_FETCH_PERF_EN adds saturating fetch/stall
// counters.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   pc_src            next-PC select (see pc_fetch_unit_pkg::pc_src_e)
//   branch_offset     sign-extended branch immediate, in words
//   jump_index        jump index field
//   pc_update         commit strobe (honoured only in S_VALID)
//   stall             blocks pc_update while high
//   imem_req/_addr    fetch request and address (address == pc)
//   imem_ready/_rdata memory response
//   instr/instr_valid latched instruction and its validity for pc
//   pc, pc_plus4      current PC and pc + 4 (combinational)
//   fetch_count       (PC_FETCH_PERF_EN) accepted fetch responses
//   stall_count       (PC_FETCH_PERF_EN) S_VALID cycles with pc_update & stall
// ----------------------------------------------------------------------------
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        pc_src,
  input  logic [31:0]       branch_offset,
  input  logic [25:0]       jump_index,
  input  logic              pc_update,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       instr_q;
  logic              instr_valid_q;
  logic              imem_req_q;
  logic              commit_s;
  logic              accept_s;

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc_calc (
    .pc_i            (pc_q),
    .pc_src_i        (pc_src),
    .branch_offset_i (branch_offset),
    .jump_index_i    (jump_index),
    .next_pc_o       (pc_d),
    .pc_plus4_o      (pc_plus4)
  );

  // pc_update outside S_VALID and imem_ready outside S_REQ are ignored here.
  assign commit_s = (state_q == S_VALID) && pc_update && !stall;
  assign accept_s = (state_q == S_REQ) && imem_ready;

  // Fetch FSM: pc, latched instruction and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      case (state_q)
        // One quiet cycle lets memory drop any transaction cut by reset.
        S_IDLE: begin
          state_q    <= S_REQ;
          imem_req_q <= 1'b1;
        end
        S_REQ: begin
          if (accept_s) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= S_VALID;
          end else begin
            state_q <= S_REQ;
          end
        end
        S_VALID: begin
          if (commit_s) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= S_REQ;
          end else begin
            state_q <= S_VALID;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          instr_valid_q <= 1'b0;
          imem_req_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] fetch_count_d;
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;
  logic        stall_hit_s;

  assign stall_hit_s = (state_q == S_VALID) && pc_update && stall;

  // Saturating increments for both performance counters.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (accept_s && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (stall_hit_s && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_count_q <= 32'h0000_0000;
      stall_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed scenarios followed by randomized traffic. A transaction-level model
// (current pc, whether a fetch is outstanding, whether an instruction is held)
// predicts every output each cycle; directed steps add literal expectations.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pc_src;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic        pc_update;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_src        (pc_src),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .pc_update     (pc_update),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4)
`ifdef PC_FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Reference next PC from the plain arithmetic rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] src,
                                           input logic [31:0] off, input logic [25:0] ji);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (src == 2'b01) return p4 + off * 32'd4;
    else if (src == 2'b10) return (p4 & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
    else return p4;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Behavioural model state.
  logic [31:0] m_pc, m_instr, m_fetch, m_stalls;
  bit          m_valid, m_pending, m_fresh;
  bit          m_live = 1'b0;

  // Model update on each rising edge from the inputs presented before it.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_pc      <= 32'h0000_0000;
      m_instr   <= 32'h0000_0000;
      m_valid   <= 1'b0;
      m_pending <= 1'b0;
      m_fresh   <= 1'b1;
      m_fetch   <= 32'h0000_0000;
      m_stalls  <= 32'h0000_0000;
      m_live    <= 1'b1;
    end else if (m_live) begin
      if (m_fresh) begin
        m_fresh   <= 1'b0;
        m_pending <= 1'b1;
      end else if (m_pending) begin
        if (imem_ready) begin
          m_instr   <= imem_rdata;
          m_pending <= 1'b0;
          m_valid   <= 1'b1;
          m_fetch   <= sat_inc(m_fetch);
        end
      end else if (m_valid && pc_update) begin
        if (stall) begin
          m_stalls <= sat_inc(m_stalls);
        end else begin
          m_pc      <= ref_next(m_pc, pc_src, branch_offset, jump_index);
          m_valid   <= 1'b0;
          m_pending <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check32("pc", pc, m_pc);
      check32("imem_addr", imem_addr, m_pc);
      check32("pc_plus4", pc_plus4, m_pc + 32'd4);
      check1("imem_req", imem_req, m_pending);
      check1("instr_valid", instr_valid, m_valid);
      check32("instr", instr, m_instr);
`ifdef PC_FETCH_PERF_EN
      check32("fetch_count", fetch_count, m_fetch);
      check32("stall_count", stall_count, m_stalls);
`endif
    end
  end

  bit rnd_ready = 1'b0;
  bit rnd_rdata = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (rnd_rdata) imem_rdata = $urandom;
    if (rnd_ready) imem_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!instr_valid && n < 100) begin
      tick();
      n++;
    end
    check1("wait_valid", instr_valid, 1'b1);
  endtask

  task automatic do_commit(input logic [1:0] src, input logic [31:0] off,
                           input logic [25:0] ji, input logic [31:0] exp_addr);
    wait_valid();
    pc_src        = src;
    branch_offset = off;
    jump_index    = ji;
    stall         = 1'b0;
    pc_update     = 1'b1;
    tick();
    pc_update     = 1'b0;
    pc_src        = 2'($urandom);
    branch_offset = $urandom;
    jump_index    = 26'($urandom);
    check32("commit_addr", imem_addr, exp_addr);
    check1("commit_req", imem_req, 1'b1);
  endtask

  logic [31:0] saved_pc, saved_instr, saved_stalls;

  initial begin
    reset_n       = 1'b0;
    pc_src        = 2'b00;
    branch_offset = 32'd0;
    jump_index    = 26'd0;
    pc_update     = 1'b0;
    stall         = 1'b0;
    imem_ready    = 1'b1;
    imem_rdata    = 32'hDEAD_0000;

    // Pin the reference arithmetic with hand-computed values.
    check32("model_branch_m2", ref_next(32'h0000_0100, 2'b01, 32'hFFFF_FFFE, 26'd0), 32'h0000_00FC);
    check32("model_jump", ref_next(32'h3000_0010, 2'b10, 32'd0, 26'h000_0040), 32'h3000_0100);
    check32("model_rsvd", ref_next(32'h3000_0010, 2'b11, 32'd0, 26'h000_0040), 32'h3000_0014);
    check32("model_wrap", ref_next(32'hFFFF_FFFC, 2'b00, 32'd0, 26'd0), 32'h0000_0000);
    check32("model_selfloop", ref_next(32'h0000_0040, 2'b01, 32'hFFFF_FFFF, 26'd0), 32'h0000_0040);

    // Reset, then zero-wait memory.
    repeat (3) tick();
    check32("rst_pc", pc, 32'h0000_0000);
    check32("rst_instr", instr, 32'h0000_0000);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_req", imem_req, 1'b0);
    reset_n = 1'b1;
    tick();
    check1("first_req", imem_req, 1'b1);
    check32("first_addr", imem_addr, 32'h0000_0000);
    tick();
    check1("first_valid", instr_valid, 1'b1);
    check32("first_instr", instr, 32'hDEAD_0000);

    // Chain of commits covering every select and the wrap boundary.
    rnd_ready = 1'b1;
    rnd_rdata = 1'b1;
    do_commit(2'b10, 32'h1234_5678, 26'h000_0040, 32'h0000_0100);
    do_commit(2'b01, 32'hFFFF_FFFE, 26'h3FF_FFFF, 32'h0000_00FC);
    do_commit(2'b01, 32'h0BFF_FFC4, 26'h000_0000, 32'h3000_0010);
    do_commit(2'b10, 32'h0000_0000, 26'h000_0040, 32'h3000_0100);
    do_commit(2'b01, 32'hFFFF_FFFF, 26'h000_0000, 32'h3000_0100);
    do_commit(2'b11, 32'h0000_0100, 26'h000_0040, 32'h3000_0104);
    do_commit(2'b01, 32'h33FF_FFBD, 26'h000_0000, 32'hFFFF_FFFC);
    do_commit(2'b00, 32'h0000_0000, 26'h000_0000, 32'h0000_0000);

    // Three wait cycles with a pc_update pulse during the request.
    wait_valid();
    rnd_ready  = 1'b0;
    imem_ready = 1'b0;
    do_commit(2'b00, 32'd0, 26'd0, 32'h0000_0004);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        pc_update  = 1'b1;
        pc_src     = 2'b10;
        jump_index = 26'h155_5555;
      end
      tick();
      pc_update = 1'b0;
      check32("wait_addr", imem_addr, 32'h0000_0004);
      check1("wait_req", imem_req, 1'b1);
      check1("wait_valid_low", instr_valid, 1'b0);
    end
    imem_ready  = 1'b1;
    saved_instr = imem_rdata;
    tick();
    check1("wait_valid_rise", instr_valid, 1'b1);
    check32("wait_instr", instr, saved_instr);
    // Ready outside a request is ignored.
    for (int i = 0; i < 3; i++) begin
      tick();
      check32("ignored_ready_instr", instr, saved_instr);
      check1("ignored_ready_req", imem_req, 1'b0);
    end

    // Stall held for four cycles with pc_update high.
    saved_pc     = pc;
    saved_stalls = m_stalls;
    pc_src       = 2'b00;
    pc_update    = 1'b1;
    stall        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check32("stall_pc", pc, saved_pc);
      check1("stall_valid", instr_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    pc_update = 1'b0;
    check32("stall_commit_pc", pc, saved_pc + 32'd4);
`ifdef PC_FETCH_PERF_EN
    check32("stall_count_4", stall_count, saved_stalls + 32'd4);
`endif

    // Reset during a request with ready asserted in the same cycle.
    wait_valid();
    imem_ready = 1'b0;
    saved_pc   = pc;
    do_commit(2'b00, 32'd0, 26'd0, saved_pc + 32'd4);
    reset_n    = 1'b0;
    imem_ready = 1'b1;
    tick();
    check32("midreset_instr", instr, 32'h0000_0000);
    check32("midreset_pc", pc, 32'h0000_0000);
    check1("midreset_valid", instr_valid, 1'b0);
    check1("midreset_req", imem_req, 1'b0);
    reset_n = 1'b1;
    tick();
    check1("restart_req", imem_req, 1'b1);
    check32("restart_addr", imem_addr, 32'h0000_0000);

    // Randomized traffic, including occasional resets.
    rnd_ready = 1'b1;
    for (int i = 0; i < 800; i++) begin
      pc_update     = ($urandom_range(0, 1) == 1);
      stall         = ($urandom_range(0, 3) == 0);
      pc_src        = 2'($urandom);
      branch_offset = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)));
      jump_index    = 26'($urandom);
      reset_n       = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset_n   = 1'b1;
    pc_update = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
